riptide_pe_fu: RTL and testbench

Parametrised RipTide processing element: a μcore wrapped around a configurable integer functional unit, with two buffered NoC input channels, an output FIFO, and per-destination fanout handshaking. It fires when its configured operands are present and output space exists. It replaces the single-channel PE shell with a configurable fanout count, buffer depth and operand source. Configuration loads through a two-word daisy chain shared with neighbouring PEs.

---
 rtl/riptide_pe_fu.sv | 99 +++++++++
 tb/tb_riptide_pe_fu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riptide_pe_fu.sv
// riptide_pe_fu: RipTide PE (two buffered operand channels A/B, configurable ALU, output FIFO with per-destination fanout, two-word config daisy chain on cfg_in/cfg_out)
module riptide_pe_fu #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT = 2,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctrl_en,
  input  logic                    ctrl_clear,
  output logic                    ctrl_done,
  input  logic [1:0]              noc_ivalid,
  input  logic [2*DATA_WIDTH-1:0] noc_in,
  output logic [1:0]              noc_oready,
  output logic [DATA_WIDTH-1:0]   noc_out,
  output logic [NUM_OUT-1:0]      noc_ovalid,
  input  logic [NUM_OUT-1:0]      noc_iready,
  input  logic                    cfg_en,
  input  logic [DATA_WIDTH-1:0]   cfg_in,
  output logic [DATA_WIDTH-1:0]   cfg_out
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int PW = OBUF_DEPTH > 1 ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  logic [DATA_WIDTH-1:0] cfg_ctrl, cfg_const, reg_a, reg_b, op_b, result;
  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  logic [3:0] op;
  logic [SW-1:0] shamt;
  logic [NUM_OUT-1:0] mask, sent;
  logic [1:0] full, consume, accept;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic need_b, fire, pop, nonempty;
  assign op = cfg_ctrl[3:0];
  assign mask = cfg_ctrl[5 +: NUM_OUT];
  assign need_b = (op != 4'd11) & ~cfg_ctrl[4];
  assign op_b = need_b ? reg_b : cfg_const;
  assign shamt = op_b[SW-1:0];
  assign nonempty = count != '0;
  assign pop = nonempty & (&(~mask | sent | noc_iready));
  assign fire = ctrl_en & ~cfg_en & ~ctrl_clear & full[0] & (full[1] | ~need_b)
              & ((count < CW'(OBUF_DEPTH)) | pop);
  assign consume = {fire & need_b, fire};
  assign noc_oready = rst ? 2'b00 : (~full | consume);
  assign accept = noc_ivalid & noc_oready & {2{~ctrl_clear}};
  assign noc_ovalid = {NUM_OUT{nonempty}} & mask & ~sent;
  assign noc_out = nonempty ? mem[rptr] : '0;
  assign ctrl_done = ~|full & ~nonempty;
  assign cfg_out = cfg_ctrl;
  always_comb begin
    result = '0;
    case (op)
      4'd0:    result = reg_a + op_b;
      4'd1:    result = reg_a - op_b;
      4'd2:    result = reg_a & op_b;
      4'd3:    result = reg_a | op_b;
      4'd4:    result = reg_a ^ op_b;
      4'd5:    result = reg_a << shamt;
      4'd6:    result = reg_a >> shamt;
      4'd7:    result = $signed(reg_a) >>> shamt;
      4'd8:    result = {{(DATA_WIDTH-1){1'b0}}, $signed(reg_a) < $signed(op_b)};
      4'd9:    result = {{(DATA_WIDTH-1){1'b0}}, reg_a < op_b};
      4'd10:   result = {{(DATA_WIDTH-1){1'b0}}, reg_a == op_b};
      4'd11:   result = reg_a;
      default: result = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ctrl <= '0;
      cfg_const <= '0;
    end else if (cfg_en) begin
      cfg_const <= cfg_in;
      cfg_ctrl <= cfg_const;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) full <= '0;
    else full <= accept | (full & ~consume);
  end
  always_ff @(posedge clk) begin
    if (accept[0]) reg_a <= noc_in[0 +: DATA_WIDTH];
    if (accept[1]) reg_b <= noc_in[DATA_WIDTH +: DATA_WIDTH];
    if (fire) mem[wptr] <= result;
  end
  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      sent <= '0;
    end else begin
      if (fire) wptr <= (wptr == PW'(OBUF_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop) rptr <= (rptr == PW'(OBUF_DEPTH - 1)) ? '0 : rptr + 1'b1;
      count <= count + CW'(fire) - CW'(pop);
      sent <= pop ? '0 : sent | (noc_ovalid & noc_iready);
    end
  end
endmodule

// File: tb/tb_riptide_pe_fu.sv
// tb_riptide_pe_fu: scoreboard bench for riptide_pe_fu with per-destination expected queues
module tb_riptide_pe_fu;
  logic clk = 1'b0, rst, ctrl_en, ctrl_clear, ctrl_done, cfg_en;
  logic [1:0] noc_ivalid, noc_oready, noc_ovalid, noc_iready;
  logic [63:0] noc_in;
  logic [31:0] noc_out, cfg_in, cfg_out;
  int total = 0, bad = 0;
  logic [31:0] q0[$], q1[$];
  logic [31:0] e;
  logic [3:0] ops [11] = '{4'd7, 4'd8, 4'd9, 4'd13, 4'd5, 4'd6, 4'd1, 4'd10, 4'd2, 4'd3, 4'd11};
  logic [31:0] as [11] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3, 32'h8000_0000,
                          32'd3, 32'd9, 32'hF0, 32'hF0, 32'h1234};
  logic [31:0] bs [11] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd36, 32'd31, 32'd5, 32'd9, 32'h3C, 32'h0F, 32'd0};
  logic [31:0] es [11] = '{32'hFFFF_FFFC, 32'd1, 32'd0, 32'd0, 32'd48, 32'd1, 32'hFFFF_FFFE, 32'd1,
                          32'h30, 32'hFF, 32'h1234};
  riptide_pe_fu dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .ctrl_clear(ctrl_clear), .ctrl_done(ctrl_done),
    .noc_ivalid(noc_ivalid), .noc_in(noc_in), .noc_oready(noc_oready), .noc_out(noc_out),
    .noc_ovalid(noc_ovalid), .noc_iready(noc_iready), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_out(cfg_out)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && !ctrl_clear) begin
      if (noc_ovalid[0] && noc_iready[0]) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL dest0_unexpected: got %h, expected nothing", noc_out);
        end else begin
          e = q0.pop_front();
          if (noc_out !== e) begin
            bad++;
            $display("FAIL dest0_data: got %h, expected %h", noc_out, e);
          end
        end
      end
      if (noc_ovalid[1] && noc_iready[1]) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL dest1_unexpected: got %h, expected nothing", noc_out);
        end else begin
          e = q1.pop_front();
          if (noc_out !== e) begin
            bad++;
            $display("FAIL dest1_data: got %h, expected %h", noc_out, e);
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_load(input logic [31:0] ctrl, input logic [31:0] konst);
    cfg_en = 1'b1;
    cfg_in = ctrl;
    tick();
    cfg_in = konst;
    tick();
    cfg_en = 1'b0;
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ch);
    logic [1:0] pend, got;
    int t;
    pend = ch;
    t = 0;
    noc_in = {b, a};
    noc_ivalid = ch;
    while (pend != 2'b00 && t < 50) begin
      @(negedge clk);
      got = pend & noc_oready;
      tick();
      pend = pend & ~got;
      noc_ivalid = pend;
      t++;
    end
    if (pend != 2'b00) begin
      total++;
      bad++;
      $display("FAIL send_timeout: pending %b, expected 00", pend);
    end
    noc_ivalid = 2'b00;
  endtask
  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: q0=%0d q1=%0d left, expected 0", q0.size(), q1.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (noc_oready !== 2'b00) begin bad++; $display("FAIL rst_oready: got %b, expected 00", noc_oready); end
    rst = 1'b0;
    tick();
    total++;
    if (noc_oready !== 2'b11) begin bad++; $display("FAIL post_rst_oready: got %b, expected 11", noc_oready); end
    total++;
    if (noc_ovalid !== 2'b00 || noc_out !== 32'd0) begin
      bad++;
      $display("FAIL rst_out: got ovalid=%b out=%h, expected 00/0", noc_ovalid, noc_out);
    end
    total++;
    if (ctrl_done !== 1'b1 || cfg_out !== 32'd0) begin
      bad++;
      $display("FAIL rst_done_cfg: got done=%b cfg=%h, expected 1/0", ctrl_done, cfg_out);
    end
  endtask
  task automatic test_add();
    cfg_load(32'h20, 32'd0);
    noc_iready = 2'b11;
    q0.push_back(32'd12);
    send(32'd5, 32'd7, 2'b11);
    total++;
    if (noc_ovalid !== 2'b00) begin bad++; $display("FAIL add_early: got ovalid=%b, expected 00", noc_ovalid); end
    tick();
    total++;
    if (noc_ovalid !== 2'b01 || noc_out !== 32'd12) begin
      bad++;
      $display("FAIL add_latency: got ovalid=%b out=%0d, expected 01/12", noc_ovalid, noc_out);
    end
    tick();
    total++;
    if (ctrl_done !== 1'b1) begin bad++; $display("FAIL add_done: got %b, expected 1", ctrl_done); end
  endtask
  task automatic test_const();
    cfg_load(32'h31, 32'd3);
    send(32'd0, 32'd99, 2'b10);
    q0.push_back(32'd7);
    send(32'd10, 32'd0, 2'b01);
    wait_drain();
    tick();
    total++;
    if (ctrl_done !== 1'b0 || noc_oready !== 2'b01) begin
      bad++;
      $display("FAIL const_held: got done=%b oready=%b, expected 0/01", ctrl_done, noc_oready);
    end
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    total++;
    if (ctrl_done !== 1'b1 || cfg_out !== 32'h31 || noc_oready !== 2'b11) begin
      bad++;
      $display("FAIL const_clear: got done=%b cfg=%h oready=%b, expected 1/31/11", ctrl_done, cfg_out, noc_oready);
    end
  endtask
  task automatic test_fanout();
    cfg_load(32'h60, 32'd0);
    noc_iready = 2'b01;
    q0.push_back(32'd3);
    q1.push_back(32'd3);
    send(32'd1, 32'd2, 2'b11);
    tick();
    total++;
    if (noc_ovalid !== 2'b11) begin bad++; $display("FAIL fan_both: got %b, expected 11", noc_ovalid); end
    tick();
    total++;
    if (noc_ovalid !== 2'b10) begin bad++; $display("FAIL fan_sent0: got %b, expected 10", noc_ovalid); end
    tick();
    total++;
    if (noc_ovalid !== 2'b10 || ctrl_done !== 1'b0) begin
      bad++;
      $display("FAIL fan_hold: got ovalid=%b done=%b, expected 10/0", noc_ovalid, ctrl_done);
    end
    noc_iready = 2'b11;
    tick();
    total++;
    if (noc_ovalid !== 2'b00 || ctrl_done !== 1'b1) begin
      bad++;
      $display("FAIL fan_pop: got ovalid=%b done=%b, expected 00/1", noc_ovalid, ctrl_done);
    end
  endtask
  task automatic test_full();
    noc_iready = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      q0.push_back(32'(k * 11));
      q1.push_back(32'(k * 11));
    end
    for (int k = 1; k <= 3; k++) send(32'(k * 10), 32'(k), 2'b11);
    noc_in = {32'd4, 32'd40};
    noc_ivalid = 2'b11;
    tick();
    tick();
    tick();
    total++;
    if (noc_oready !== 2'b00) begin bad++; $display("FAIL full_oready: got %b, expected 00", noc_oready); end
    total++;
    if (noc_ovalid !== 2'b11 || noc_out !== 32'd11) begin
      bad++;
      $display("FAIL full_head: got ovalid=%b out=%0d, expected 11/11", noc_ovalid, noc_out);
    end
    noc_iready = 2'b11;
    send(32'd40, 32'd4, 2'b11);
    wait_drain();
    tick();
    total++;
    if (ctrl_done !== 1'b1) begin bad++; $display("FAIL full_done: got %b, expected 1", ctrl_done); end
  endtask
  task automatic test_ops();
    for (int i = 0; i < 11; i++) begin
      cfg_load(32'h20 | 32'(ops[i]), 32'd0);
      q0.push_back(es[i]);
      send(as[i], bs[i], ops[i] == 4'd11 ? 2'b01 : 2'b11);
      wait_drain();
    end
  endtask
  task automatic test_clear();
    cfg_load(32'h60, 32'd0);
    noc_iready = 2'b00;
    send(32'd1, 32'd1, 2'b11);
    send(32'd2, 32'd2, 2'b11);
    tick();
    tick();
    total++;
    if (noc_ovalid !== 2'b11 || ctrl_done !== 1'b0) begin
      bad++;
      $display("FAIL clr_pre: got ovalid=%b done=%b, expected 11/0", noc_ovalid, ctrl_done);
    end
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    total++;
    if (noc_ovalid !== 2'b00 || ctrl_done !== 1'b1 || cfg_out !== 32'h60) begin
      bad++;
      $display("FAIL clr_post: got ovalid=%b done=%b cfg=%h, expected 00/1/60", noc_ovalid, ctrl_done, cfg_out);
    end
    noc_iready = 2'b11;
    tick();
    tick();
    total++;
    if (noc_ovalid !== 2'b00) begin bad++; $display("FAIL clr_stale: got %b, expected 00", noc_ovalid); end
  endtask
  initial begin
    rst = 1'b1;
    ctrl_en = 1'b1;
    ctrl_clear = 1'b0;
    cfg_en = 1'b0;
    cfg_in = '0;
    noc_ivalid = 2'b00;
    noc_in = '0;
    noc_iready = 2'b11;
    test_reset();
    test_add();
    test_const();
    test_fanout();
    test_full();
    test_ops();
    test_clear();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL leftover: got q0=%0d q1=%0d, expected 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
